// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: sequences fetch/decode/execute over a shared datapath,
// stalls on memory via mem_ready and counts retired instructions.
module mips_multicycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegDst,
  output logic                 MemToReg,
  output logic                 RegWrite,
  output logic                 AluSrcA,
  output logic [1:0]           AluSrcB,
  output logic [2:0]           AluControl,
  output logic [1:0]           PCSrc,
  output logic                 pc_en,
  output logic                 illegal_op,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  stateT                stateReg;
  stateT                stateNext;
  logic [CNT_WIDTH-1:0] retiredReg;
  logic                 retireNow;
  logic                 pcWrite;
  logic                 branch;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= FETCH;
      retiredReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (retireNow) begin
        retiredReg <= retiredReg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    stateNext  = stateReg;
    retireNow  = 1'b0;
    pcWrite    = 1'b0;
    branch     = 1'b0;
    mem_req    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    AluSrcA    = 1'b0;
    AluSrcB    = 2'b00;
    AluControl = 3'b000;
    PCSrc      = 2'b00;
    illegal_op = 1'b0;

    case (stateReg)
      FETCH: begin
        // PC+4 is computed every fetch cycle but only committed when the read completes
        mem_req    = 1'b1;
        AluSrcB    = 2'b01;
        AluControl = ALU_ADD;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          pcWrite   = 1'b1;
          stateNext = DECODE;
        end
      end
      DECODE: begin
        AluSrcB    = 2'b11;
        AluControl = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: stateNext = MEMADR;
          OP_RTYPE:     stateNext = EXEC;
          OP_BEQ:       stateNext = BRANCH;
          OP_ADDI:      stateNext = ADDIEX;
          OP_J:         stateNext = JUMP;
          default: begin
            illegal_op = 1'b1;
            stateNext  = FETCH;
          end
        endcase
      end
      MEMADR: begin
        AluSrcA    = 1'b1;
        AluSrcB    = 2'b10;
        AluControl = ALU_ADD;
        stateNext  = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          stateNext = MEMWB;
        end
      end
      MEMWB: begin
        MemToReg  = 1'b1;
        RegWrite  = 1'b1;
        retireNow = 1'b1;
        stateNext = FETCH;
      end
      MEMWR: begin
        // The store retires on the cycle the memory accepts it
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retireNow = 1'b1;
          stateNext = FETCH;
        end
      end
      EXEC: begin
        AluSrcA   = 1'b1;
        stateNext = ALUWB;
        case (funct)
          6'b100000: AluControl = ALU_ADD;
          6'b100010: AluControl = ALU_SUB;
          6'b100100: AluControl = ALU_AND;
          6'b100101: AluControl = ALU_OR;
          6'b101010: AluControl = ALU_SLT;
          default: begin
            AluControl = ALU_ADD;
            illegal_op = 1'b1;
            stateNext  = FETCH;
          end
        endcase
      end
      ALUWB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        retireNow = 1'b1;
        stateNext = FETCH;
      end
      BRANCH: begin
        AluSrcA    = 1'b1;
        AluControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
        retireNow  = 1'b1;
        stateNext  = FETCH;
      end
      ADDIEX: begin
        AluSrcA    = 1'b1;
        AluSrcB    = 2'b10;
        AluControl = ALU_ADD;
        stateNext  = ADDIWB;
      end
      ADDIWB: begin
        RegWrite  = 1'b1;
        retireNow = 1'b1;
        stateNext = FETCH;
      end
      JUMP: begin
        PCSrc     = 2'b10;
        pcWrite   = 1'b1;
        retireNow = 1'b1;
        stateNext = FETCH;
      end
      default: begin
        stateNext = FETCH;
      end
    endcase

    // Reset silences every control so an abandoned instruction has no side effects
    if (reset) begin
      retireNow  = 1'b0;
      pcWrite    = 1'b0;
      branch     = 1'b0;
      mem_req    = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemToReg   = 1'b0;
      RegWrite   = 1'b0;
      AluSrcA    = 1'b0;
      AluSrcB    = 2'b00;
      AluControl = 3'b000;
      PCSrc      = 2'b00;
      illegal_op = 1'b0;
    end
  end

  assign pc_en   = pcWrite | (branch & zero);
  assign state   = stateReg;
  assign retired = retiredReg;

endmodule
